// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, timeout counter width.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int TO_CNT_WIDTH = 5;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data-memory bus signals of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  we_i;
  logic [1:0]            size_i;
  logic                  unsigned_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic                  rsp_valid_o;
  logic [31:0]           rdata_o;
  logic                  misaligned_o;
  logic                  bus_err_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_ack_i;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  req_valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rdata_o, misaligned_o, bus_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rdata_o, misaligned_o, bus_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte enables, store replication, load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    misaligned  = 1'b0;
    be          = 4'b0000;
    wdata_lanes = '0;
    load_data   = '0;
    shifted     = rdata_word >> {addr_lo, 3'b000};
    case (size_e'(size))
      SZ_BYTE: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misaligned  = addr_lo[0];
        be          = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misaligned  = (addr_lo != 2'b00);
        be          = 4'b1111;
        wdata_lanes = wdata;
        load_data   = shifted;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one outstanding load/store over a valid/ack bus.
// Optional bus timeout abort is built when LSU_TIMEOUT_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  state_e                state, next_state;
  logic                  accept, ack_take;
  logic                  req_we, req_unsigned;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [31:0]           rdata_q;
  logic                  mis_q;
  logic                  in_idle, in_req, in_resp;
  logic [1:0]            al_size, al_addr_lo;
  logic                  al_misaligned;
  logic [3:0]            al_be;
  logic [31:0]           al_wdata, al_load;

  assign in_idle = (state == ST_IDLE);
  assign in_req  = (state == ST_REQ);
  assign in_resp = (state == ST_RESP);

  // In IDLE the aligner checks the incoming request; afterwards it works on the captured one.
  assign al_size    = in_idle ? bus.size_i : req_size;
  assign al_addr_lo = in_idle ? bus.addr_i[1:0] : req_addr[1:0];

  lsu_align u_align (
    .size        (al_size),
    .addr_lo     (al_addr_lo),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rdata_word  (bus.mem_rdata_i),
    .misaligned  (al_misaligned),
    .be          (al_be),
    .wdata_lanes (al_wdata),
    .load_data   (al_load)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [TO_CNT_WIDTH-1:0] TIMEOUT_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TO_CNT_WIDTH-1:0] to_cnt;
  logic                    timeout_hit;
  logic                    err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                to_cnt <= '0;
    else if (!in_req)          to_cnt <= '0;
    else if (!bus.mem_ack_i)   to_cnt <= to_cnt + TO_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            err_q <= 1'b0;
    else if (accept)       err_q <= 1'b0;
    else if (timeout_hit)  err_q <= 1'b1;
  end

  assign bus.bus_err_o = in_resp & err_q;
`else
  assign bus.bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    ack_take   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          accept     = 1'b1;
          next_state = al_misaligned ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack_i) begin
          ack_take   = 1'b1;
          next_state = ST_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (to_cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          next_state  = ST_RESP;
        end
`endif
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture at acceptance; load data is captured (already extended) on the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_we       <= 1'b0;
      req_unsigned <= 1'b0;
      req_size     <= 2'b00;
      req_addr     <= '0;
      req_wdata    <= '0;
      rdata_q      <= '0;
      mis_q        <= 1'b0;
    end else if (accept) begin
      req_we       <= bus.we_i;
      req_unsigned <= bus.unsigned_i;
      req_size     <= bus.size_i;
      req_addr     <= bus.addr_i;
      req_wdata    <= bus.wdata_i;
      rdata_q      <= '0;
      mis_q        <= al_misaligned;
    end else if (ack_take) begin
      rdata_q      <= req_we ? '0 : al_load;
    end
  end

  assign bus.req_ready_o  = in_idle;
  assign bus.rsp_valid_o  = in_resp;
  assign bus.rdata_o      = in_resp ? rdata_q : '0;
  assign bus.misaligned_o = in_resp & mis_q;
  assign bus.mem_req_o    = in_req;
  assign bus.mem_we_o     = in_req & req_we;
  assign bus.mem_addr_o   = in_req ? {req_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_be_o     = in_req ? al_be : 4'b0000;
  assign bus.mem_wdata_o  = in_req ? al_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses vs a byte-level model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          req_cycles;
    int          rsp_cycle;
    int          rsp_pulses;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    logic        mwe;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        stable;
    logic        ready_after;
    logic        timed_out;
  } obs_t;

  // Reference built from byte lanes: which bytes an access touches and what value they form.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] memword, output logic mis,
                                output logic [3:0] be, output logic [31:0] lanes,
                                output logic [31:0] rdata);
    int n, off;
    longint unsigned val;
    off = int'(addr % 4);
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    mis = (n == 0) ? 1'b1 : ((off % n) != 0);
    be = 4'b0; lanes = '0; rdata = '0; val = 0;
    if (n == 0) return;
    for (int i = 0; i < 4; i++) begin
      be[i] = (i >= off) && (i < off + n);
      lanes[8*i +: 8] = wdata[8*(i % n) +: 8];
    end
    if (mis || we) return;
    for (int j = 0; j < n; j++)
      val = val + (longint'(memword[8*(off+j) +: 8]) << (8*j));
    if (!uns && (((val >> (8*n - 1)) & 1) == 1))
      val = val - (64'd1 << (8*n));
    rdata = val[31:0];
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] memword, input int waits, output obs_t o);
    int seen;
    o = '{default: 0};
    o.stable = 1'b1;
    o.timed_out = 1'b1;
    seen = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.we_i        = we;
    bus.size_i      = size;
    bus.unsigned_i  = uns;
    bus.addr_i      = addr;
    bus.wdata_i     = wdata;
    bus.mem_rdata_i = memword;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid_i = 1'b0;
      bus.mem_ack_i = 1'b0;
      if (bus.mem_req_o) begin
        seen++;
        if (seen == 1) begin
          o.maddr = bus.mem_addr_o; o.be = bus.mem_be_o;
          o.mwdata = bus.mem_wdata_o; o.mwe = bus.mem_we_o;
        end else if (bus.mem_addr_o !== o.maddr || bus.mem_be_o !== o.be ||
                     bus.mem_wdata_o !== o.mwdata || bus.mem_we_o !== o.mwe) begin
          o.stable = 1'b0;
        end
        if (seen == waits + 1) bus.mem_ack_i = 1'b1;
      end
      if (bus.rsp_valid_o) begin
        o.rsp_pulses++;
        if (o.rsp_pulses == 1) begin
          o.rsp_cycle = k; o.rdata = bus.rdata_o;
          o.mis = bus.misaligned_o; o.err = bus.bus_err_o;
        end
      end else if (o.rsp_pulses > 0) begin
        o.ready_after = bus.req_ready_o;
        o.timed_out = 1'b0;
        break;
      end
    end
    bus.mem_ack_i = 1'b0;
    o.req_cycles = seen;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.mem_req_o, bus.mem_we_o, bus.misaligned_o,
         bus.bus_err_o} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 100000", {bus.req_ready_o, bus.rsp_valid_o,
               bus.mem_req_o, bus.mem_we_o, bus.misaligned_o, bus.bus_err_o});
    end
    checks++;
    if ({bus.rdata_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o} !== 100'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected all 0", bus.rdata_o, bus.mem_addr_o,
               bus.mem_wdata_o, bus.mem_be_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    obs_t o;
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1003, 32'h0, 32'h80112233, 0, o);
    checks++;
    if (o.rdata !== 32'hFFFFFF80) begin
      errors++; $display("[TB] FAIL lb_rdata: got %h expected FFFFFF80", o.rdata);
    end
    checks++;
    if (o.rsp_cycle !== 2 || o.req_cycles !== 1 || o.ready_after !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lb_latency: got rsp@%0d req=%0d rdy=%b expected rsp@2 req=1 rdy=1",
               o.rsp_cycle, o.req_cycles, o.ready_after);
    end
    checks++;
    if (o.maddr !== 32'h1000 || o.be !== 4'b1000 || o.mwe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lb_bus: got addr=%h be=%b we=%b expected 00001000/1000/0", o.maddr, o.be, o.mwe);
    end
    issue(1'b0, SZ_BYTE, 1'b1, 32'h1003, 32'h0, 32'h80112233, 0, o);
    checks++;
    if (o.rdata !== 32'h00000080) begin
      errors++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", o.rdata);
    end
    issue(1'b0, SZ_HALF, 1'b1, 32'h1002, 32'h0, 32'h80112233, 0, o);
    checks++;
    if (o.rdata !== 32'h00008011) begin
      errors++; $display("[TB] FAIL lhu_rdata: got %h expected 00008011", o.rdata);
    end
  endtask

  task automatic test_store_half();
    obs_t o;
    issue(1'b1, SZ_HALF, 1'b0, 32'h2002, 32'hDEADBEEF, 32'h55555555, 0, o);
    checks++;
    if (o.be !== 4'b1100 || o.mwdata !== 32'hBEEFBEEF || o.mwe !== 1'b1 || o.maddr !== 32'h2000) begin
      errors++;
      $display("[TB] FAIL sh_bus: got be=%b wd=%h we=%b addr=%h expected 1100/BEEFBEEF/1/00002000",
               o.be, o.mwdata, o.mwe, o.maddr);
    end
    checks++;
    if (o.rdata !== 32'h0 || o.mis !== 1'b0) begin
      errors++; $display("[TB] FAIL sh_rsp: got rdata=%h mis=%b expected 0/0", o.rdata, o.mis);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    issue(1'b0, SZ_WORD, 1'b0, 32'h2001, 32'h0, 32'h12345678, 0, o);
    checks++;
    if (o.req_cycles !== 0 || o.rsp_cycle !== 1 || o.mis !== 1'b1 || o.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lw_misaligned: got req=%0d rsp@%0d mis=%b rd=%h expected 0/1/1/0",
               o.req_cycles, o.rsp_cycle, o.mis, o.rdata);
    end
    issue(1'b1, SZ_ILL, 1'b0, 32'h2000, 32'hFFFF0000, 32'h0, 0, o);
    checks++;
    if (o.req_cycles !== 0 || o.rsp_cycle !== 1 || o.mis !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_size: got req=%0d rsp@%0d mis=%b expected 0/1/1",
               o.req_cycles, o.rsp_cycle, o.mis);
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    issue(1'b1, SZ_WORD, 1'b0, 32'h2004, 32'hCAFEF00D, 32'h0, 5, o);
    checks++;
    if (o.req_cycles !== 6 || o.stable !== 1'b1 || o.rsp_pulses !== 1 || o.rsp_cycle !== 7) begin
      errors++;
      $display("[TB] FAIL sw_wait5: got req=%0d stable=%b pulses=%0d rsp@%0d expected 6/1/1/7",
               o.req_cycles, o.stable, o.rsp_pulses, o.rsp_cycle);
    end
    checks++;
    if (o.be !== 4'b1111 || o.mwdata !== 32'hCAFEF00D || o.maddr !== 32'h2004) begin
      errors++;
      $display("[TB] FAIL sw_bus: got be=%b wd=%h addr=%h expected 1111/CAFEF00D/00002004",
               o.be, o.mwdata, o.maddr);
    end
  endtask

  task automatic test_ignored_inputs();
    int seen;
    logic done;
    @(negedge clk);
    bus.mem_ack_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.mem_req_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_ack: got rsp=%b rdy=%b req=%b expected 0/1/0",
                 bus.rsp_valid_o, bus.req_ready_o, bus.mem_req_o);
      end
    end
    bus.mem_ack_i   = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.we_i = 1'b0; bus.size_i = SZ_WORD; bus.unsigned_i = 1'b0;
    bus.addr_i = 32'h3000; bus.mem_rdata_i = 32'hA5A5_0F0F;
    @(posedge clk);
    seen = 0; done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      bus.addr_i = 32'h4444; bus.mem_ack_i = 1'b0;
      if (bus.mem_req_o) begin
        seen++;
        if (seen == 3) bus.mem_ack_i = 1'b1;
        if (bus.mem_addr_o !== 32'h3000) begin
          errors++; $display("[TB] FAIL busy_addr: got %h expected 00003000", bus.mem_addr_o);
        end
      end
      if (bus.rsp_valid_o) begin
        bus.req_valid_i = 1'b0;
        done = 1'b1;
        checks++;
        if (bus.rdata_o !== 32'hA5A5_0F0F) begin
          errors++; $display("[TB] FAIL busy_rdata: got %h expected A5A50F0F", bus.rdata_o);
        end
      end
    end
    checks++;
    if (!done || seen !== 3) begin
      errors++; $display("[TB] FAIL busy_rsp: got done=%b req=%0d expected 1/3", done, seen);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.mem_req_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_no_queue: got rdy=%b req=%b rsp=%b expected 1/0/0",
               bus.req_ready_o, bus.mem_req_o, bus.rsp_valid_o);
    end
  endtask

  task automatic test_reset_mid_req();
    obs_t o;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.we_i = 1'b1; bus.size_i = SZ_WORD;
    bus.addr_i = 32'h6000; bus.wdata_i = 32'h11112222;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req_o !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_req: got %b expected 1", bus.mem_req_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got req=%b rdy=%b we=%b expected 0/1/0",
               bus.mem_req_o, bus.req_ready_o, bus.mem_we_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, SZ_HALF, 1'b0, 32'h6002, 32'h0, 32'h8001_7FFF, 1, o);
    checks++;
    if (o.rdata !== 32'hFFFF8001 || o.rsp_cycle !== 3) begin
      errors++;
      $display("[TB] FAIL after_reset_lh: got %h rsp@%0d expected FFFF8001 rsp@3", o.rdata, o.rsp_cycle);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
`ifdef LSU_TIMEOUT_EN
    issue(1'b0, SZ_WORD, 1'b0, 32'h5000, 32'h0, 32'h12345678, 1000, o);
    checks++;
    if (o.req_cycles !== 16 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.timed_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_abort: got req=%0d err=%b rd=%h to=%b expected 16/1/0/0",
               o.req_cycles, o.err, o.rdata, o.timed_out);
    end
    issue(1'b0, SZ_WORD, 1'b0, 32'h5000, 32'h0, 32'h12345678, 15, o);
    checks++;
    if (o.req_cycles !== 16 || o.err !== 1'b0 || o.rdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL timeout_ack_wins: got req=%0d err=%b rd=%h expected 16/0/12345678",
               o.req_cycles, o.err, o.rdata);
    end
`else
    issue(1'b0, SZ_WORD, 1'b0, 32'h5000, 32'h0, 32'h12345678, 30, o);
    checks++;
    if (o.req_cycles !== 31 || o.err !== 1'b0 || o.rdata !== 32'h12345678 || o.timed_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_wait: got req=%0d err=%b rd=%h to=%b expected 31/0/12345678/0",
               o.req_cycles, o.err, o.rdata, o.timed_out);
    end
`endif
  endtask

  task automatic test_random();
    obs_t o;
    logic we, uns, e_mis;
    logic [1:0] size;
    logic [31:0] addr, wdata, word, e_lanes, e_rdata;
    logic [3:0] e_be;
    int waits;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom; wdata = $urandom; word = $urandom;
      waits = $urandom_range(0, 3);
      model(we, size, uns, addr, wdata, word, e_mis, e_be, e_lanes, e_rdata);
      issue(we, size, uns, addr, wdata, word, waits, o);
      checks++;
      if (o.mis !== e_mis || o.rdata !== e_rdata || o.err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_rsp[%0d]: got mis=%b rd=%h err=%b expected %b/%h/0",
                 i, o.mis, o.rdata, o.err, e_mis, e_rdata);
      end
      checks++;
      if (o.rsp_pulses !== 1 || o.ready_after !== 1'b1 || o.rsp_cycle !== (e_mis ? 1 : waits + 2)) begin
        errors++;
        $display("[TB] FAIL rand_timing[%0d]: got pulses=%0d rdy=%b rsp@%0d expected 1/1/%0d",
                 i, o.rsp_pulses, o.ready_after, o.rsp_cycle, e_mis ? 1 : waits + 2);
      end
      checks++;
      if (e_mis ? (o.req_cycles !== 0)
                : (o.req_cycles !== waits + 1 || o.be !== e_be || o.maddr !== (addr & ~32'd3) ||
                   o.mwe !== we || o.stable !== 1'b1 || (we && o.mwdata !== e_lanes))) begin
        errors++;
        $display("[TB] FAIL rand_bus[%0d]: got req=%0d be=%b addr=%h we=%b wd=%h st=%b expected req=%0d be=%b wd=%h",
                 i, o.req_cycles, o.be, o.maddr, o.mwe, o.mwdata, o.stable,
                 e_mis ? 0 : waits + 1, e_be, e_lanes);
      end
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.unsigned_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    test_reset();
    test_loads();
    test_store_half();
    test_misaligned();
    test_wait_states();
    test_ignored_inputs();
    test_reset_mid_req();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
